// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu shared definitions
// Size codes follow the load/store funct3 field.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_extend.sv
// riscv_lsu load alignment
// Picks the addressed byte/halfword from the memory word and extends it.
module riscv_lsu_extend
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_word >> {i_off, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];

    // select width and extension by the latched size code
    always_comb begin
        o_data = i_word;
        unique case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_BU: o_data = {24'h0, w_byte};
            LDST_HU: o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu load/store unit
// One memory request per access; stalls the core until the response cycle.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    lsu_state_t    r_state;
    lsu_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_off;
    logic [2:0]    r_size;
    logic          r_we;

    logic          w_illegal;
    logic          w_idle_req;
    logic          w_issue;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic [31:0]   w_ext;

    // alignment and size legality of the presented access
    always_comb begin
        w_illegal = 1'b1;
        unique case (core_size_i)
            LDST_B:  w_illegal = 1'b0;
            LDST_H:  w_illegal = core_addr_i[0];
            LDST_W:  w_illegal = |core_addr_i[1:0];
            LDST_BU: w_illegal = core_we_i;
            LDST_HU: w_illegal = core_we_i | core_addr_i[0];
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_idle_req = (r_state == IDLE) & core_req_i & ~rst_i;
    assign w_issue    = w_idle_req & ~w_illegal;

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_issue) w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // latency counter and per-access latches for the response cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_off  <= '0;
            r_size <= '0;
            r_we   <= 1'b0;
        end else if (w_issue) begin
            r_cnt  <= CNT_INIT;
            r_off  <= core_addr_i[1:0];
            r_size <= core_size_i;
            r_we   <= core_we_i;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // byte enables and replicated store data
    always_comb begin
        w_be = 4'hF;
        w_wd = core_wd_i;
        unique case (core_size_i)
            LDST_B, LDST_BU: begin
                w_be = 4'b0001 << core_addr_i[1:0];
                w_wd = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                w_be = 4'b0011 << core_addr_i[1:0];
                w_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_be = 4'hF;
                w_wd = core_wd_i;
            end
        endcase
    end

    riscv_lsu_extend u_extend (
        .i_word (mem_rd_i),
        .i_off  (r_off),
        .i_size (r_size),
        .o_data (w_ext)
    );

    assign mem_req_o    = w_issue;
    assign mem_we_o     = core_we_i;
    assign mem_be_o     = w_be;
    assign mem_addr_o   = core_addr_i;
    assign mem_wd_o     = w_wd;

    assign core_fault_o = w_idle_req & w_illegal;
    assign core_stall_o = w_issue | ((r_state == WAIT) & ~rst_i);
    assign core_rd_o    = ((r_state == RESP) & ~r_we & ~rst_i) ? w_ext : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// riscv_lsu bench: LATENCY=1 and LATENCY=3 instances
// Per-cycle expectations come from an access-level model.
module tb_riscv_lsu;

    int n_checks = 0;
    int n_errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        stall;
        logic        fault;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rq_t;

    task automatic chk(int lat, string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL L%0d %s: got %h expected %h at %0t", lat, nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_fault(logic w, logic [2:0] s, logic [31:0] a);
        int n = nbytes(s);
        if (n == 0) return 1'b1;
        if (w && s >= 3'd4) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] s, logic [31:0] a);
        int n = nbytes(s);
        int off = int'(a % 4);
        logic [3:0] b = 4'h0;
        if (n == 0) n = 4;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wd(logic [2:0] s, logic [31:0] d);
        int n = nbytes(s);
        logic [31:0] r = 32'h0;
        if (n == 0) n = 4;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = 8'((d >> (8 * (i % n))) & 32'hFF);
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] s, int off, logic [31:0] word);
        int n = nbytes(s);
        longint v, m;
        m = (longint'(1) << (8 * n)) - 1;
        v = longint'(word >> (8 * off)) & m;
        if (s < 3'd4 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
            v = v - (m + 1);
        return v[31:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : blk
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst = 1'b1;
        logic        req = 1'b0;
        logic        we = 1'b0;
        logic [2:0]  size = 3'd0;
        logic [31:0] addr = 32'h0;
        logic [31:0] wd = 32'h0;
        logic [31:0] mem_rd = 32'h0;
        logic [31:0] rd_o, maddr, mwd;
        logic        stall, fault, mreq, mwe;
        logic [3:0]  mbe;
        logic        done_f = 1'b0;

        logic [31:0] ram [64];
        logic [31:0] refm [64];
        exp_t        q[$];
        rq_t         rq[$];
        exp_t        ce;
        int          cyc = 0;

        riscv_lsu #(.LATENCY(LAT)) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .core_req_i   (req),
            .core_we_i    (we),
            .core_size_i  (size),
            .core_addr_i  (addr),
            .core_wd_i    (wd),
            .core_rd_o    (rd_o),
            .core_stall_o (stall),
            .core_fault_o (fault),
            .mem_req_o    (mreq),
            .mem_we_o     (mwe),
            .mem_be_o     (mbe),
            .mem_addr_o   (maddr),
            .mem_wd_o     (mwd),
            .mem_rd_i     (mem_rd)
        );

        always @(negedge clk) begin
            if (mreq) begin
                if (mwe) begin
                    for (int i = 0; i < 4; i++)
                        if (mbe[i]) ram[maddr[7:2]][8*i +: 8] = mwd[8*i +: 8];
                end else begin
                    rq.push_back('{ram[maddr[7:2]], cyc + LAT});
                end
            end
        end

        always @(posedge clk) begin
            cyc++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mem_rd = rq[0].d;
                void'(rq.pop_front());
            end
        end

        always @(negedge clk) begin
            if (q.size() > 0) begin
                ce = q.pop_front();
                chk(LAT, "stall", 32'(stall), 32'(ce.stall));
                chk(LAT, "fault", 32'(fault), 32'(ce.fault));
                chk(LAT, "mem_req", 32'(mreq), 32'(ce.req));
                chk(LAT, "core_rd", rd_o, ce.rd);
                if (ce.req) begin
                    chk(LAT, "mem_we", 32'(mwe), 32'(ce.we));
                    chk(LAT, "mem_be", 32'(mbe), 32'(ce.be));
                    chk(LAT, "mem_addr", maddr, ce.addr);
                    chk(LAT, "mem_wd", mwd, ce.wd);
                end
            end
        end

        task automatic step(exp_t e);
            q.push_back(e);
            @(posedge clk);
            #1;
        endtask

        task automatic idle();
            req = 1'b0;
            step('{1'b0, 1'b0, 4'h0, addr, 32'h0, 1'b0, 1'b0, 32'h0});
        endtask

        task automatic access(logic w, logic [2:0] s, logic [31:0] a, logic [31:0] d);
            logic [31:0] res;
            logic [3:0]  be;
            logic [31:0] sd;
            req = 1'b1; we = w; size = s; addr = a; wd = d;
            if (m_fault(w, s, a)) begin
                step('{1'b0, w, 4'h0, a, 32'h0, 1'b0, 1'b1, 32'h0});
                req = 1'b0;
                return;
            end
            be  = m_be(s, a);
            sd  = m_wd(s, d);
            res = w ? 32'h0 : m_load(s, int'(a % 4), refm[a[7:2]]);
            step('{1'b1, w, be, a, sd, 1'b1, 1'b0, 32'h0});
            for (int i = 0; i < LAT; i++)
                step('{1'b0, w, 4'h0, a, 32'h0, 1'b1, 1'b0, 32'h0});
            step('{1'b0, w, 4'h0, a, 32'h0, 1'b0, 1'b0, res});
            if (w)
                for (int i = 0; i < 4; i++)
                    if (be[i]) refm[a[7:2]][8*i +: 8] = sd[8*i +: 8];
            req = 1'b0;
        endtask

        task automatic put(int idx, logic [31:0] v);
            ram[idx] = v;
            refm[idx] = v;
        endtask

        initial begin
            logic [2:0] s;
            logic       w;
            for (int i = 0; i < 64; i++) put(i, $urandom);
            put(4, 32'h80FF7F01);
            req = 1'b1; size = 3'd2; addr = 32'h0;
            repeat (2) @(posedge clk);
            #1;
            chk(LAT, "rst_req", 32'(mreq), 32'h0);
            chk(LAT, "rst_stall", 32'(stall), 32'h0);
            chk(LAT, "rst_rd", rd_o, 32'h0);
            req = 1'b0;
            #2 rst = 1'b0;
            @(posedge clk);
            #1;
            idle();

            access(1'b0, 3'd0, 32'h13, 32'h0);
            access(1'b0, 3'd4, 32'h13, 32'h0);
            access(1'b1, 3'd1, 32'h22, 32'h1234ABCD);
            access(1'b0, 3'd2, 32'h06, 32'h0);
            access(1'b1, 3'd4, 32'h10, 32'h55);
            access(1'b0, 3'd7, 32'h10, 32'h0);
            idle();
            access(1'b0, 3'd2, 32'h40, 32'h0);
            access(1'b0, 3'd2, 32'h44, 32'h0);

            req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h48;
            step('{1'b1, 1'b0, 4'hF, 32'h48, 32'h0, 1'b1, 1'b0, 32'h0});
            #1 rst = 1'b1;
            #1;
            chk(LAT, "wait_rst_stall", 32'(stall), 32'h0);
            chk(LAT, "wait_rst_req", 32'(mreq), 32'h0);
            chk(LAT, "wait_rst_fault", 32'(fault), 32'h0);
            chk(LAT, "wait_rst_rd", rd_o, 32'h0);
            req = 1'b0;
            @(posedge clk);
            #1;
            chk(LAT, "rst_hold_stall", 32'(stall), 32'h0);
            #2 rst = 1'b0;
            @(posedge clk);
            #1;
            put(0, 32'h80010000);
            access(1'b0, 3'd1, 32'h02, 32'h0);

            repeat (200) begin
                if ($urandom_range(0, 5) == 0) idle();
                w = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 8) begin
                    s = 3'($urandom_range(0, 4));
                    if (s == 3'd3) s = 3'd5;
                end else begin
                    s = 3'($urandom_range(0, 7));
                end
                access(w, s, 32'($urandom_range(0, 255)), $urandom);
            end
            idle();
            done_f = 1'b1;
        end
    end

    initial begin
        chk(0, "pin_lb", m_load(3'd0, 3, 32'h80FF7F01), 32'hFFFFFF80);
        chk(0, "pin_lbu", m_load(3'd4, 3, 32'h80FF7F01), 32'h00000080);
        chk(0, "pin_lh", m_load(3'd1, 2, 32'h80010000), 32'hFFFF8001);
        chk(0, "pin_be_b", 32'(m_be(3'd0, 32'h13)), 32'h8);
        chk(0, "pin_be_h", 32'(m_be(3'd1, 32'h22)), 32'hC);
        chk(0, "pin_wd_h", m_wd(3'd1, 32'h1234ABCD), 32'hABCDABCD);
        chk(0, "pin_flt_lw", 32'(m_fault(1'b0, 3'd2, 32'h06)), 32'h1);
        chk(0, "pin_flt_sbu", 32'(m_fault(1'b1, 3'd4, 32'h10)), 32'h1);
        chk(0, "pin_ok_lhu", 32'(m_fault(1'b0, 3'd5, 32'h22)), 32'h0);
        repeat (20000) begin
            @(posedge clk);
            if (blk[0].done_f && blk[1].done_f) break;
        end
        if (!(blk[0].done_f && blk[1].done_f)) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: stimulus did not complete, got %0b%0b expected 11",
                     blk[1].done_f, blk[0].done_f);
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
